// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: resolves load-use, taken-branch,
// multi-cycle EX and memory-wait hazards, and counts frozen-PC cycles.
module hazard_stall_ctrl #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned MULTI_LAT = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_multi_start,
    input  logic              branch_taken,
    input  logic              mem_wait,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned CW = $clog2(MULTI_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        RUN      = 1'b0,
        MC_STALL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          load_use;

    // A load feeding either live source of the ID instruction; r0 is never a hazard.
    always_comb begin
        load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    end

    // Next-state and combinational pipeline controls, in hazard priority order.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;

        if (reset || mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (state == MC_STALL) begin
            if (cnt > CW'(1)) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
                cnt_nxt      = cnt - CW'(1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end else if (ex_multi_start) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            state_nxt    = MC_STALL;
            cnt_nxt      = CW'(MULTI_LAT - 1);
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a wide-counter instance and a 2-bit counter
// instance share stimulus; expected controls and counts are queued per driven cycle.
module tb_hazard_stall_ctrl;

    localparam logic [7:0] ALL_EN = 8'b11111_000;
    localparam logic [7:0] FREEZE = 8'b00000_000;
    localparam logic [7:0] LU     = 8'b00111_010;
    localparam logic [7:0] BR     = 8'b11111_110;
    localparam logic [7:0] MC     = 8'b00011_001;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        int unsigned cnt;
        int unsigned sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
    logic       ex_multi_start, branch_taken, mem_wait;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_bubble, exmem_bubble;
    logic [15:0] stall_cycles;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_bubble, s_exmem_bubble;
    logic [1:0]  s_stall_cycles;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_AW(5), .MULTI_LAT(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_multi_start(ex_multi_start), .branch_taken(branch_taken), .mem_wait(mem_wait),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.REG_AW(5), .MULTI_LAT(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_multi_start(ex_multi_start), .branch_taken(branch_taken), .mem_wait(mem_wait),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .exmem_bubble(s_exmem_bubble), .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Queue the expectation for the cycle whose inputs are now applied, then advance.
    task automatic step(input string tag, input logic [7:0] ctl, input int unsigned cnt);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.cnt = cnt;
        e.sat = (cnt > 3) ? 3 : cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; mem_wait = 1'b0; ex_multi_start = 1'b0; branch_taken = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".ctl"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                        ifid_flush, idex_bubble, exmem_bubble}), 32'(e.ctl));
            check({e.tag, ".sat_ctl"}, 32'({s_pc_en, s_ifid_en, s_idex_en, s_exmem_en,
                                            s_memwb_en, s_ifid_flush, s_idex_bubble,
                                            s_exmem_bubble}), 32'(e.ctl));
            check({e.tag, ".cnt"}, 32'(stall_cycles), 32'(e.cnt));
            check({e.tag, ".sat"}, 32'(s_stall_cycles), 32'(e.sat));
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        step("reset", FREEZE, 0);
        idle();
        step("idle0", ALL_EN, 0);

        // load-use via rs, then via rt, then non-hazards
        load(5'd5); id_rs = 5'd5; id_uses_rs = 1'b1;
        step("t1_lu_rs", LU, 0);
        idle();
        step("t1_after", ALL_EN, 1);
        load(5'd7); id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd7;
        step("lu_rt", LU, 1);
        idle(); load(5'd5); id_rs = 5'd5;
        step("no_use_rs", ALL_EN, 2);
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        step("no_regwr", ALL_EN, 2);

        // multi-cycle op, branch in the start cycle and mid-stall is ignored
        idle(); ex_multi_start = 1'b1; branch_taken = 1'b1;
        step("t2_mc0", MC, 2);
        branch_taken = 1'b0;
        step("t2_mc1", MC, 3);
        branch_taken = 1'b1;
        step("t2_mc2", MC, 4);
        branch_taken = 1'b0;
        step("t2_rel", ALL_EN, 5);
        idle();
        step("t2_after", ALL_EN, 5);

        // taken branch squashes a load-use hazard
        load(5'd9); id_rs = 5'd9; id_uses_rs = 1'b1; branch_taken = 1'b1;
        step("t3_br", BR, 5);
        idle();
        step("t3_after", ALL_EN, 5);

        // memory wait inside a multi-cycle stall holds the countdown
        ex_multi_start = 1'b1;
        step("t4_mc0", MC, 5);
        step("t4_mc1", MC, 6);
        mem_wait = 1'b1;
        step("t4_w0", FREEZE, 7);
        step("t4_w1", FREEZE, 8);
        mem_wait = 1'b0;
        step("t4_mc2", MC, 9);
        step("t4_rel", ALL_EN, 10);
        idle();
        step("t4_after", ALL_EN, 10);
        mem_wait = 1'b1; load(5'd3); id_rs = 5'd3; id_uses_rs = 1'b1;
        step("wait_run", FREEZE, 10);
        idle();
        step("wait_after", ALL_EN, 11);

        // reset in the middle of a multi-cycle stall
        ex_multi_start = 1'b1;
        step("t5_mc0", MC, 11);
        step("t5_mc1", MC, 12);
        reset = 1'b1;
        step("t5_rst", FREEZE, 13);
        idle();
        step("t5_run", ALL_EN, 0);

        // back-to-back load-use stalls saturate the 2-bit counter; r0 never stalls
        load(5'd4); id_rt = 5'd4; id_uses_rt = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("t6_lu%0d", i), LU, i);
        idle();
        step("t6_after", ALL_EN, 5);
        load(5'd0); id_rs = 5'd0; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1;
        step("t6_r0", ALL_EN, 5);
        idle();
        step("t6_end", ALL_EN, 5);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completion");
        $fatal(1, "timeout");
    end

endmodule
